// File: rtl/switches_poll_ctrl.sv
// switches_poll_ctrl: polls the switches PIO at a fixed rate, debounces the value
// and reports each stable change through a one-entry coalescing event register.
module switches_poll_ctrl #(
  parameter int POLL_PERIOD  = 1000,
  parameter int STABLE_COUNT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [1:0]  m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [7:0]  evt_data,
  output logic [7:0]  evt_changed,
  output logic [7:0]  stable_value,
  output logic [15:0] event_count,
  output logic        overflow,
  input  logic        clear_overflow
);
  localparam int TW = $clog2(POLL_PERIOD);
  localparam logic [TW-1:0] RELOAD = TW'(POLL_PERIOD - 1);
  localparam logic [3:0] SC = 4'(STABLE_COUNT);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, CAPTURE = 2'd2, UPDATE = 2'd3;
  logic [1:0] state;
  logic [TW-1:0] timer;
  logic [7:0] sample, candidate, mask;
  logic [3:0] match_cnt, nxt_cnt;
  logic start, accept, take, unused_hi;
  assign unused_hi = ^m_readdata[31:8];
  assign m_address = 2'd0;
  assign m_read = state == READ;
  assign start = state == IDLE && enable && timer == '0;
  assign nxt_cnt = sample == candidate ? (match_cnt >= SC ? SC : match_cnt + 4'd1) : 4'd1;
  assign accept = state == UPDATE && nxt_cnt == SC && sample != stable_value;
  assign take = !evt_valid || evt_ready;
  assign mask = stable_value ^ sample;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      timer <= RELOAD;
      sample <= '0;
      candidate <= '0;
      match_cnt <= '0;
      stable_value <= '0;
      event_count <= '0;
      evt_valid <= 1'b0;
      evt_data <= '0;
      evt_changed <= '0;
      overflow <= 1'b0;
    end else begin
      timer <= (!enable || start) ? RELOAD : (timer != '0 ? timer - 1'b1 : timer);
      state <= start ? READ : state == READ ? CAPTURE : state == CAPTURE ? UPDATE : IDLE;
      if (state == CAPTURE) sample <= m_readdata[7:0];
      if (state == UPDATE) begin
        candidate <= sample;
        match_cnt <= nxt_cnt;
      end
      // a pending, unconsumed event is overwritten and its change mask accumulated
      if (accept) begin
        stable_value <= sample;
        event_count <= event_count + 16'd1;
        evt_valid <= 1'b1;
        evt_data <= sample;
        evt_changed <= take ? mask : evt_changed | mask;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
      overflow <= (accept && !take) || (overflow && !clear_overflow);
    end
  end
endmodule

// File: tb/tb_switches_poll_ctrl.sv
// tb_switches_poll_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a poll-schedule / sample-history reference model.
module tb_switches_poll_ctrl;
  localparam int P = 7, S = 4;
  logic clk = 0, reset_n = 0, enable = 0, evt_ready = 0, clear_overflow = 0;
  logic [31:0] m_readdata = '0;
  logic [1:0] m_address;
  logic m_read, evt_valid, overflow;
  logic [7:0] evt_data, evt_changed, stable_value;
  logic [15:0] event_count;
  logic [7:0] sw = '0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  switches_poll_ctrl #(.POLL_PERIOD(P), .STABLE_COUNT(S)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .m_address(m_address),
    .m_read(m_read), .m_readdata(m_readdata), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_data(evt_data), .evt_changed(evt_changed),
    .stable_value(stable_value), .event_count(event_count), .overflow(overflow),
    .clear_overflow(clear_overflow)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  // consecutive edges with enable sampled high; polls fall on multiples of P
  int n = 0;
  always @(posedge clk or negedge reset_n) n = !reset_n ? 0 : (enable ? n + 1 : 0);
  logic ev, ovf, v1, v2, resp, acc, coal, er, rdy;
  logic [7:0] ed, ec, st, s1, s2;
  logic [15:0] cnt;
  logic [7:0] hist[$];
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {ev, ovf, v1, v2, resp} = '0;
      {ed, ec, st, s1, s2} = '0;
      cnt = '0;
      hist.delete();
      m_readdata = '0;
    end else begin
      er = n > 0 && n % P == 0;
      check("m_read", m_read, er);
      check("m_address", m_address, 2'd0);
      check("evt_valid", evt_valid, ev);
      check("evt_data", evt_data, ed);
      check("evt_changed", evt_changed, ec);
      check("stable", stable_value, st);
      check("count", event_count, cnt);
      check("overflow", overflow, ovf);
      rdy = evt_ready;
      acc = 1'b0;
      if (v2) begin
        hist.push_back(s2);
        if (hist.size() > S) void'(hist.pop_front());
        acc = hist.size() == S && s2 != st;
        foreach (hist[i]) if (hist[i] != s2) acc = 1'b0;
      end
      coal = acc && ev && !rdy;
      ovf = coal ? 1'b1 : (clear_overflow ? 1'b0 : ovf);
      if (acc) begin
        ec = coal ? ec | (st ^ s2) : st ^ s2;
        ed = s2;
        ev = 1'b1;
        st = s2;
        cnt++;
      end else if (ev && rdy) ev = 1'b0;
      v2 = v1;
      s2 = s1;
      v1 = er;
      s1 = sw;
      // PIO slave: data valid from the read cycle through the following one, junk otherwise
      if (m_read) begin
        m_readdata = {$urandom()};
        m_readdata[7:0] = sw;
        resp = 1'b1;
      end else if (resp) resp = 1'b0;
      else m_readdata = {$urandom()};
    end
  end
  task automatic tick(input int k = 1);
    repeat (k) @(posedge clk);
    #2;
  endtask
  task automatic wait_read();
    logic seen = 1'b0;
    for (int i = 0; i < 4 * P && !seen; i++) begin
      @(negedge clk);
      seen = m_read;
    end
    check("rd_seen", seen, 1'b1);
  endtask
  task automatic poll(input logic [7:0] v);
    sw = v;
    wait_read();
    tick(3);
  endtask
  initial begin
    tick(3);
    check("rst_read", m_read, 0);
    check("rst_valid", evt_valid, 0);
    check("rst_count", event_count, 0);
    reset_n = 1;
    tick(2);
    enable = 1;
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      check("early_rd", m_read, 0);
    end
    @(negedge clk);
    check("first_rd", m_read, 1);
    repeat (9) poll(8'h00);
    check("zero_cnt", event_count, 0);
    check("zero_valid", evt_valid, 0);
    repeat (3) poll(8'h5A);
    check("pre_valid", evt_valid, 0);
    poll(8'h5A);
    check("5a_valid", evt_valid, 1);
    check("5a_data", evt_data, 8'h5A);
    check("5a_chg", evt_changed, 8'h5A);
    check("5a_cnt", event_count, 1);
    repeat (3) poll(8'h5A);
    check("5a_again", event_count, 1);
    reset_n = 0;
    tick();
    reset_n = 1;
    poll(8'h5A); poll(8'h5B);
    repeat (3) poll(8'h5A);
    check("bnc_pre", event_count, 0);
    poll(8'h5A);
    check("bnc_cnt", event_count, 1);
    check("bnc_data", evt_data, 8'h5A);
    evt_ready = 1;
    tick();
    evt_ready = 0;
    repeat (4) poll(8'h0F);
    check("0f_data", evt_data, 8'h0F);
    repeat (4) poll(8'hF0);
    check("co_data", evt_data, 8'hF0);
    check("co_chg", evt_changed, 8'hFF);
    check("co_ovf", overflow, 1);
    check("co_cnt", event_count, 3);
    clear_overflow = 1;
    tick();
    clear_overflow = 0;
    check("ovf_clr", overflow, 0);
    repeat (3) poll(8'h33);
    wait_read();
    @(posedge clk);
    tick();
    evt_ready = 1;
    tick();
    evt_ready = 0;
    check("sc_valid", evt_valid, 1);
    check("sc_data", evt_data, 8'h33);
    check("sc_chg", evt_changed, 8'hC3);
    check("sc_ovf", overflow, 0);
    sw = 8'h77;
    wait_read();
    tick();
    enable = 0;
    for (int i = 0; i < 3 * P; i++) begin
      @(negedge clk);
      check("off_rd", m_read, 0);
    end
    tick();
    enable = 1;
    repeat (3) poll(8'h77);
    check("off_data", evt_data, 8'h77);
    check("off_cnt", event_count, 5);
    wait_read();
    #1 reset_n = 0;
    #1;
    check("mr_read", m_read, 0);
    check("mr_valid", evt_valid, 0);
    check("mr_stable", stable_value, 0);
    check("mr_count", event_count, 0);
    check("mr_data", evt_data, 0);
    tick();
    reset_n = 1;
    repeat (2500) begin
      tick();
      if ($urandom_range(0, 29) == 0) sw = 8'($urandom_range(0, 3) * 8'h55);
      evt_ready = $urandom_range(0, 3) == 0;
      clear_overflow = $urandom_range(0, 19) == 0;
      enable = $urandom_range(0, 149) != 0;
    end
    tick(3 * P);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
